// File: rtl/traffic_interval_timer.sv
// Interval timer and walk-request latch for the traffic-light sequencer.
// Optional macro REMAIN_OUT_EN adds the live countdown output 'remaining'.
module traffic_interval_timer #(
    parameter int TICK_DIV = 4,
    parameter int TW       = 4,
    parameter int T_BASE   = 6,
    parameter int T_EXT    = 3,
    parameter int T_YEL    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    interval,
    input  logic          start_timer,
    output logic          expired,
    input  logic          prog_sync,
    input  logic [1:0]    time_param_sel,
    input  logic [TW-1:0] time_value,
    input  logic          walk_btn,
    input  logic          wr_reset,
    output logic          wr,
    output logic          tick
`ifdef REMAIN_OUT_EN
    ,
    output logic [TW:0]   remaining
`endif
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [TW:0]   count, count_next;
    logic          expired_next;
    logic [DW-1:0] divider;
    logic [TW-1:0] base_t, ext_t, yel_t;
    logic [TW:0]   load_val;

    assign tick = (divider == DW'(TICK_DIV - 1));

`ifdef REMAIN_OUT_EN
    assign remaining = count;
`endif

    // Double base is formed one bit wider so it never wraps.
    always_comb begin
        load_val = {1'b0, base_t};
        case (interval)
            3'b001:  load_val = {1'b0, ext_t};
            3'b010:  load_val = {1'b0, yel_t};
            3'b011:  load_val = {base_t, 1'b0};
            default: load_val = {1'b0, base_t};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            expired <= expired_next;
        end
    end

    // A start in the final-tick cycle takes priority and suppresses expiry.
    always_comb begin
        state_next   = state;
        count_next   = count;
        expired_next = 1'b0;
        if (start_timer) begin
            state_next = COUNT;
            count_next = load_val;
        end else if (state == COUNT && tick) begin
            if (count == (TW+1)'(1)) begin
                state_next   = IDLE;
                count_next   = '0;
                expired_next = 1'b1;
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= '0;
            base_t  <= TW'(T_BASE);
            ext_t   <= TW'(T_EXT);
            yel_t   <= TW'(T_YEL);
            wr      <= 1'b0;
        end else begin
            if (start_timer || tick)
                divider <= '0;
            else
                divider <= divider + 1'b1;

            if (prog_sync) begin
                case (time_param_sel)
                    2'd0: if (time_value != '0) base_t <= time_value;
                    2'd1: if (time_value != '0) ext_t  <= time_value;
                    2'd2: if (time_value != '0) yel_t  <= time_value;
                    default: begin
                        base_t <= TW'(T_BASE);
                        ext_t  <= TW'(T_EXT);
                        yel_t  <= TW'(T_YEL);
                    end
                endcase
            end

            // A press coinciding with the clear must not be lost.
            if (walk_btn)
                wr <= 1'b1;
            else if (wr_reset)
                wr <= 1'b0;
        end
    end

endmodule
